psi_divider: RTL and testbench

//   Programmable divider that regenerates the PSI feedback waveform from the divisor

---
 rtl/psi_divider.sv | 135 +++++++++++++
 tb/tb_psi_divider.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psi_divider.sv
// psi_divider: regenerates the PSI feedback square wave from the regulator divisor.
// psiOut is high for (shadowDiv+1) cycles, then low for (shadowDiv+1) cycles.
// A new divisor is taken only at a period boundary, so no phase is ever cut short.
// Optional feature macro: PSI_DIV_LOCK_DETECT_EN enables the divisor-lock detector.
// Without it, locked is held at 0 and the port list is unchanged.
module psi_divider #(
  parameter int WIDTH      = 8,
  parameter int RESET_DIV  = 127,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] divIn,
  output logic             psiOut,
  output logic             periodDone,
  output logic [WIDTH-1:0] curDiv,
  output logic             locked
);

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] shadow_div, shadow_next;
  logic             start_period;

  // Next-state logic: count each phase down to zero, reload from the shadow
  // divisor between phases, and latch a fresh divisor only at period start.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    shadow_next  = shadow_div;
    start_period = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next   = HIGH;
          shadow_next  = divIn;
          cnt_next     = divIn;
          start_period = 1'b1;
        end
      end
      HIGH: begin
        if (cnt != ZERO) begin
          cnt_next = cnt - ONE;
        end else begin
          state_next = LOW;
          cnt_next   = shadow_div;
        end
      end
      LOW: begin
        if (cnt != ZERO) begin
          cnt_next = cnt - ONE;
        end else if (en) begin
          state_next   = HIGH;
          shadow_next  = divIn;
          cnt_next     = divIn;
          start_period = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; outputs are registered from the next state so they line
  // up exactly with the phase they describe (periodDone in the last LOW cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= ZERO;
      shadow_div <= RESET_VAL;
      psiOut     <= 1'b0;
      periodDone <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      shadow_div <= shadow_next;
      psiOut     <= (state_next == HIGH);
      periodDone <= (state_next == LOW) && (cnt_next == ZERO);
    end
  end

  assign curDiv = shadow_div;

`ifdef PSI_DIV_LOCK_DETECT_EN
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_COUNT);
  localparam logic [LCW-1:0] LOCK_ONE = LCW'(1);

  logic [LCW-1:0] lock_cnt, lock_next;

  // Lock counter: counts back-to-back periods whose new divisor equals the
  // previous one; a start from IDLE is treated as a change, IDLE clears it.
  always_comb begin
    lock_next = lock_cnt;
    if (state_next == IDLE) begin
      lock_next = '0;
    end else if (start_period) begin
      if ((state == LOW) && (divIn == shadow_div)) begin
        lock_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_ONE;
      end else begin
        lock_next = '0;
      end
    end
  end

  // Lock register and its registered indicator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lock_cnt <= lock_next;
      locked   <= (lock_next == LOCK_MAX);
    end
  end
`else
  // Lock detector not built: the expression is constant 0 for any legal LOCK_COUNT.
  assign locked = (LOCK_COUNT < 0);
`endif

endmodule

// File: tb/tb_psi_divider.sv
// tb_psi_divider: self-checking bench for psi_divider.
// A period-position model predicts every output each cycle; directed
// literal checks pin the key timing points of the waveform.
module tb_psi_divider;

  localparam int LOCK_COUNT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] divIn = 8'd3;
  logic       psiOut;
  logic       periodDone;
  logic [7:0] curDiv;
  logic       locked;

  int  vectors = 0;
  int  miscompares = 0;
  bit  checkEn = 1'b0;

  int  mPos, mDiv, mLock;
  bit  mActive;

  psi_divider #(.WIDTH(8), .RESET_DIV(127), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .divIn(divIn),
    .psiOut(psiOut),
    .periodDone(periodDone),
    .curDiv(curDiv),
    .locked(locked)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // One comparison: counts it, reports a FAIL line on mismatch
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive the inputs
  task automatic applyStimulus(input logic e, input logic [7:0] d);
    en    = e;
    divIn = d;
  endtask

  // Advance n clocks, landing 2 ns after the edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Begin a new period in the model, updating the lock run length
  task automatic modelStart(input bit fromRun);
    if (fromRun && int'(divIn) == mDiv)
      mLock = (mLock < LOCK_COUNT) ? mLock + 1 : mLock;
    else
      mLock = 0;
    mDiv    = int'(divIn);
    mPos    = 0;
    mActive = 1'b1;
  endtask

  // Model: position within a period of 2*(div+1) cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive = 1'b0;
      mPos    = 0;
      mDiv    = 127;
      mLock   = 0;
    end else if (!mActive) begin
      if (en) modelStart(1'b0);
    end else if (mPos == 2 * mDiv + 1) begin
      if (en) modelStart(1'b1);
      else begin
        mActive = 1'b0;
        mLock   = 0;
      end
    end else begin
      mPos++;
    end
  end

  // Per-cycle comparison against the model on the falling edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("psiOut", int'(psiOut), int'(mActive && mPos <= mDiv));
      checkOutput("periodDone", int'(periodDone), int'(mActive && mPos == 2 * mDiv + 1));
      checkOutput("curDiv", int'(curDiv), mDiv);
`ifdef PSI_DIV_LOCK_DETECT_EN
      checkOutput("locked", int'(locked), int'(mLock == LOCK_COUNT));
`else
      checkOutput("locked", int'(locked), 0);
`endif
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int expLock;
    bit found;
`ifdef PSI_DIV_LOCK_DETECT_EN
    expLock = 1;
`else
    expLock = 0;
`endif
    rst = 1'b1;
    applyStimulus(1'b0, 8'd3);
    cycles(2);
    checkEn = 1'b1;
    checkOutput("rst_curDiv", int'(curDiv), 127);
    checkOutput("rst_psi", int'(psiOut), 0);
    checkOutput("rst_done", int'(periodDone), 0);
    checkOutput("rst_locked", int'(locked), 0);
    rst = 1'b0;
    cycles(1);

    // Basic 4/4 waveform with divIn=3
    applyStimulus(1'b1, 8'd3);
    checkOutput("t1_psi_before", int'(psiOut), 0);
    cycles(1);
    checkOutput("t1_psi_rise", int'(psiOut), 1);
    checkOutput("t1_curDiv", int'(curDiv), 3);
    cycles(3);
    checkOutput("t1_psi_high4", int'(psiOut), 1);
    cycles(1);
    checkOutput("t1_psi_fall", int'(psiOut), 0);
    cycles(3);
    checkOutput("t1_done", int'(periodDone), 1);
    checkOutput("t1_psi_low4", int'(psiOut), 0);
    cycles(1);
    checkOutput("t1_psi_rise2", int'(psiOut), 1);
    checkOutput("t1_done_clr", int'(periodDone), 0);

    // Divisor change in the 2nd HIGH cycle takes effect next period
    cycles(1);
    applyStimulus(1'b1, 8'd5);
    cycles(6);
    checkOutput("t2_done_old", int'(periodDone), 1);
    checkOutput("t2_curDiv_old", int'(curDiv), 3);
    cycles(1);
    checkOutput("t2_curDiv_new", int'(curDiv), 5);
    checkOutput("t2_psi_new", int'(psiOut), 1);
    cycles(11);
    checkOutput("t2_done_new", int'(periodDone), 1);

    // divIn=0: toggle every cycle
    applyStimulus(1'b1, 8'd0);
    cycles(1);
    checkOutput("t3_psi_1", int'(psiOut), 1);
    checkOutput("t3_curDiv0", int'(curDiv), 0);
    cycles(1);
    checkOutput("t3_psi_0", int'(psiOut), 0);
    checkOutput("t3_done", int'(periodDone), 1);
    cycles(1);
    checkOutput("t3_psi_1b", int'(psiOut), 1);
    cycles(5);

    // divIn=255: 256 high / 256 low
    applyStimulus(1'b1, 8'd255);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycles(1);
      if (curDiv == 8'd255) found = 1'b1;
    end
    checkOutput("t3_div255_start", int'(found), 1);
    applyStimulus(1'b1, 8'd2);
    checkOutput("t3_psi255_first", int'(psiOut), 1);
    cycles(255);
    checkOutput("t3_psi255_last_high", int'(psiOut), 1);
    cycles(1);
    checkOutput("t3_psi255_low", int'(psiOut), 0);
    cycles(255);
    checkOutput("t3_done255", int'(periodDone), 1);
    cycles(1);
    checkOutput("t4_curDiv2", int'(curDiv), 2);
    checkOutput("t4_psi2", int'(psiOut), 1);

    // en dropped during HIGH: period completes, then IDLE
    applyStimulus(1'b0, 8'd2);
    cycles(5);
    checkOutput("t4_done", int'(periodDone), 1);
    cycles(1);
    checkOutput("t4_idle_psi", int'(psiOut), 0);
    checkOutput("t4_idle_done", int'(periodDone), 0);
    cycles(2);
    checkOutput("t4_idle_psi2", int'(psiOut), 0);

    // en dropped then reasserted before LOW end: seamless
    applyStimulus(1'b1, 8'd1);
    cycles(1);
    checkOutput("t4_restart", int'(psiOut), 1);
    applyStimulus(1'b0, 8'd1);
    cycles(2);
    applyStimulus(1'b1, 8'd1);
    cycles(1);
    checkOutput("t4_seam_done", int'(periodDone), 1);
    cycles(1);
    checkOutput("t4_seam_psi", int'(psiOut), 1);

    // Asynchronous reset mid-LOW
    cycles(2);
    checkOutput("t4_midlow_psi", int'(psiOut), 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("t4_rst_psi", int'(psiOut), 0);
    checkOutput("t4_rst_curDiv", int'(curDiv), 127);
    checkOutput("t4_rst_done", int'(periodDone), 0);
    cycles(2);
    rst = 1'b0;

    // Lock detect with divIn held at 1, then a change
    cycles(1);
    checkOutput("t5_p1_psi", int'(psiOut), 1);
    checkOutput("t5_p1_locked", int'(locked), 0);
    cycles(12);
    checkOutput("t5_p4_locked", int'(locked), 0);
    cycles(4);
    checkOutput("t5_p5_locked", int'(locked), expLock);
    applyStimulus(1'b1, 8'd3);
    cycles(4);
    checkOutput("t5_p6_curDiv", int'(curDiv), 3);
    checkOutput("t5_p6_locked", int'(locked), 0);

    applyStimulus(1'b0, 8'd3);
    cycles(12);
    checkOutput("end_idle_psi", int'(psiOut), 0);
    checkEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
